// File: rtl/dispatch_sched.sv
// -----------------------------------------------------------------------------
// dispatch_credit
//   Free-slot counter for one issue queue. It starts full (DEPTH credits).
//   A push takes one credit and an issue returns one. A push and an issue in
//   the same cycle cancel each other. An issue when the counter is already
//   full is dropped, so the count never goes above DEPTH. A flush refills the
//   counter to DEPTH.
//
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     push       : one entry written into the queue
//     issue      : one entry popped from the queue
//     flush      : squash; queue contents are discarded
//     avail      : at least one free slot
// -----------------------------------------------------------------------------
module dispatch_credit #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic issue,
  input  logic flush,
  output logic avail
);

  localparam int W = $clog2(DEPTH + 1);
  localparam logic [W-1:0] FULL = W'(DEPTH);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] credit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit <= FULL;
    end else if (flush) begin
      credit <= FULL;
    end else if (push && !issue) begin
      credit <= credit - ONE;
    end else if (issue && !push && (credit != FULL)) begin
      credit <= credit + ONE;
    end
  end

  assign avail = (credit != '0);

endmodule

// -----------------------------------------------------------------------------
// dispatch_sched
//   Dispatch-stage scheduler. It sits between the decoder and the four issue
//   queues (ALU, MUL, DIV, AGU).
//   - Each queue has a credit counter that tracks its free slots.
//   - Each dispatched instruction gets a ROB tag from the circular tail
//     pointer.
//   - Fetch is back-pressured when the target queue or the ROB is full.
//   - After a branch or JALR is dispatched, dispatch is held until the branch
//     resolves or a flush arrives.
//
//   Ports:
//     clk, rst_n                 : clock, asynchronous active-low reset
//     inst_valid                 : decoded instruction present
//     queue_{alu,mul,div,agu}_en : target queue selected by the decoder
//     ctrl_branch, ctrl_jmp_reg  : instruction is a conditional branch / JALR
//     inst_ready                 : instruction accepted (or dropped) this cycle
//     {alu,mul,div,agu}_push     : write strobe to the issue queue
//     rob_alloc, rob_tag         : ROB allocation strobe and tag (ROB tail)
//     {alu,mul,div,agu}_issue    : queue popped one entry (returns a credit)
//     rob_retire                 : ROB head retired
//     br_resolved                : pending branch resolved, no mispredict
//     flush                      : mispredict squash
//     dispatch_err               : more than one queue enable asserted
// -----------------------------------------------------------------------------
module dispatch_sched #(
  parameter int ALU_DEPTH = 4,
  parameter int MUL_DEPTH = 4,
  parameter int DIV_DEPTH = 2,
  parameter int AGU_DEPTH = 4,
  parameter int ROB_DEPTH = 16,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inst_valid,
  input  logic             queue_alu_en,
  input  logic             queue_mul_en,
  input  logic             queue_div_en,
  input  logic             queue_agu_en,
  input  logic             ctrl_branch,
  input  logic             ctrl_jmp_reg,
  output logic             inst_ready,
  output logic             alu_push,
  output logic             mul_push,
  output logic             div_push,
  output logic             agu_push,
  output logic             rob_alloc,
  output logic [TAG_W-1:0] rob_tag,
  input  logic             alu_issue,
  input  logic             mul_issue,
  input  logic             div_issue,
  input  logic             agu_issue,
  input  logic             rob_retire,
  input  logic             br_resolved,
  input  logic             flush,
  output logic             dispatch_err
);

  localparam int CNT_W = $clog2(ROB_DEPTH + 1);
  localparam logic [CNT_W-1:0] ROB_FULL = CNT_W'(ROB_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);

  typedef enum logic {RUN, WAIT_BR} state_t;

  state_t           state, state_nx;
  logic [3:0]       en;        // {agu, div, mul, alu}
  logic [3:0]       avail;
  logic [3:0]       push;
  logic [3:0]       issue;
  logic             one_hot;
  logic             multi;
  logic             tgt_avail;
  logic             rob_full;
  logic             fire;
  logic             retire_eff;
  logic [TAG_W-1:0] head, tail;
  logic [TAG_W-1:0] head_adv;
  logic [CNT_W-1:0] rob_cnt;

  // Target decode. en & (en - 1) clears the lowest set bit, so a non-zero
  // result means two or more enables are asserted.
  assign en        = {queue_agu_en, queue_div_en, queue_mul_en, queue_alu_en};
  assign multi     = ((en & (en - 4'd1)) != 4'd0);
  assign one_hot   = (en != 4'd0) && !multi;
  assign tgt_avail = ((en & avail) != 4'd0);
  assign rob_full  = (rob_cnt == ROB_FULL);
  assign issue     = {agu_issue, div_issue, mul_issue, alu_issue};

  // Instructions with no valid target (no enable, or several enables) are
  // dropped. They only need the FSM to be in RUN to be consumed.
  assign inst_ready = rst_n && !flush && (state == RUN) &&
                      (!one_hot || (tgt_avail && !rob_full));
  assign fire       = inst_valid && inst_ready && one_hot;
  assign push       = fire ? en : 4'd0;

  assign alu_push     = push[0];
  assign mul_push     = push[1];
  assign div_push     = push[2];
  assign agu_push     = push[3];
  assign rob_alloc    = fire;
  assign rob_tag      = rst_n ? tail : '0;
  assign dispatch_err = rst_n && inst_valid && multi;

  dispatch_credit #(.DEPTH(ALU_DEPTH)) u_cr_alu (
    .clk(clk), .rst_n(rst_n), .push(push[0]), .issue(issue[0]),
    .flush(flush), .avail(avail[0]));
  dispatch_credit #(.DEPTH(MUL_DEPTH)) u_cr_mul (
    .clk(clk), .rst_n(rst_n), .push(push[1]), .issue(issue[1]),
    .flush(flush), .avail(avail[1]));
  dispatch_credit #(.DEPTH(DIV_DEPTH)) u_cr_div (
    .clk(clk), .rst_n(rst_n), .push(push[2]), .issue(issue[2]),
    .flush(flush), .avail(avail[2]));
  dispatch_credit #(.DEPTH(AGU_DEPTH)) u_cr_agu (
    .clk(clk), .rst_n(rst_n), .push(push[3]), .issue(issue[3]),
    .flush(flush), .avail(avail[3]));

  // A retire is ignored when the ROB is empty. On a flush the head first
  // takes any retire from this cycle, then the tail snaps back onto it.
  assign retire_eff = rob_retire && (rob_cnt != '0);
  assign head_adv   = head + (retire_eff ? TAG_ONE : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      rob_cnt <= '0;
    end else if (flush) begin
      head    <= head_adv;
      tail    <= head_adv;
      rob_cnt <= '0;
    end else begin
      head <= head_adv;
      if (fire) begin
        tail <= tail + TAG_ONE;
      end
      if (fire && !retire_eff) begin
        rob_cnt <= rob_cnt + CNT_ONE;
      end else if (!fire && retire_eff) begin
        rob_cnt <= rob_cnt - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = RUN;
    end else begin
      unique case (state)
        RUN:     if (fire && (ctrl_branch || ctrl_jmp_reg)) state_nx = WAIT_BR;
        WAIT_BR: if (br_resolved) state_nx = RUN;
        default: state_nx = RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_dispatch_sched.sv
module tb_dispatch_sched;

  localparam logic [3:0] ALU = 4'b0001;
  localparam logic [3:0] MUL = 4'b0010;
  localparam logic [3:0] DIV = 4'b0100;
  localparam logic [3:0] AGU = 4'b1000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       inst_valid;
  logic       queue_alu_en, queue_mul_en, queue_div_en, queue_agu_en;
  logic       ctrl_branch, ctrl_jmp_reg;
  logic       inst_ready;
  logic       alu_push, mul_push, div_push, agu_push;
  logic       rob_alloc;
  logic [3:0] rob_tag;
  logic       alu_issue, mul_issue, div_issue, agu_issue;
  logic       rob_retire, br_resolved, flush;
  logic       dispatch_err;

  always #5 clk = ~clk;

  dispatch_sched dut (
    .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid),
    .queue_alu_en(queue_alu_en), .queue_mul_en(queue_mul_en),
    .queue_div_en(queue_div_en), .queue_agu_en(queue_agu_en),
    .ctrl_branch(ctrl_branch), .ctrl_jmp_reg(ctrl_jmp_reg),
    .inst_ready(inst_ready),
    .alu_push(alu_push), .mul_push(mul_push), .div_push(div_push), .agu_push(agu_push),
    .rob_alloc(rob_alloc), .rob_tag(rob_tag),
    .alu_issue(alu_issue), .mul_issue(mul_issue), .div_issue(div_issue), .agu_issue(agu_issue),
    .rob_retire(rob_retire), .br_resolved(br_resolved), .flush(flush),
    .dispatch_err(dispatch_err));

  typedef struct {
    logic       rst;
    logic       valid;
    logic [3:0] en;
    logic       br;
    logic       jr;
    logic [3:0] iss;
    logic       ret;
    logic       res;
    logic       fl;
    logic       ready;
    logic [3:0] push;
    logic       alloc;
    logic [3:0] tag;
    logic       err;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic r, input logic vl, input logic [3:0] en,
                     input logic br, input logic jr, input logic [3:0] iss,
                     input logic ret, input logic res, input logic fl,
                     input logic rdy, input logic [3:0] pu, input logic al,
                     input logic [3:0] tg, input logic er);
    vec_t v;
    v.rst = r; v.valid = vl; v.en = en; v.br = br; v.jr = jr; v.iss = iss;
    v.ret = ret; v.res = res; v.fl = fl; v.ready = rdy; v.push = pu;
    v.alloc = al; v.tag = tg; v.err = er;
    tbl.push_back(v);
  endtask

  // reset asserted with an ALU instruction present: every output must be 0
  task automatic rst_v();
    add(1, 1, ALU, 0, 0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 4'd0, 0);
  endtask
  // accepted dispatch: ctl = {jr, br}
  task automatic acc(input logic [3:0] en, input logic [3:0] tg,
                     input logic [3:0] iss, input logic [1:0] ctl);
    add(0, 1, en, ctl[0], ctl[1], iss, 0, 0, 0, 1, en, 1, tg, 0);
  endtask
  // valid instruction that must be held off
  task automatic stall(input logic [3:0] en, input logic [3:0] iss,
                       input logic ret, input logic res, input logic fl);
    add(0, 1, en, 0, 0, iss, ret, res, fl, 0, 4'd0, 0, 4'd0, 0);
  endtask
  // no instruction, side-band events only
  task automatic idle(input logic [3:0] iss, input logic ret, input logic res);
    add(0, 0, 4'd0, 0, 0, iss, ret, res, 0, 1, 4'd0, 0, 4'd0, 0);
  endtask

  task automatic chk(input string nm, input int id, input logic [3:0] got,
                     input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL vec%0d %s got %0h want %0h", id, nm, got, want);
    end
  endtask

  initial begin
    vec_t v, e;

    // 1: ALU credits run out after four, one issue lets the fifth in
    rst_v();
    for (int i = 0; i < 4; i++) acc(ALU, 4'(i), 4'd0, 2'b00);
    stall(ALU, 4'd0, 0, 0, 0);
    stall(ALU, ALU, 0, 0, 0);
    acc(ALU, 4'd4, 4'd0, 2'b00);

    // 2: DIV push+issue keeps credit at 1; ALU issue at full credit saturates
    rst_v();
    acc(DIV, 4'd0, 4'd0, 2'b00);
    acc(DIV, 4'd1, DIV, 2'b00);
    acc(DIV, 4'd2, 4'd0, 2'b00);
    stall(DIV, 4'd0, 0, 0, 0);
    idle(ALU, 0, 0);
    idle(ALU, 0, 0);
    for (int i = 0; i < 4; i++) acc(ALU, 4'(3 + i), 4'd0, 2'b00);
    stall(ALU, 4'd0, 0, 0, 0);

    // 3: fill ROB with 16 entries, 17th stalls, one retire lets it in at tag 0
    rst_v();
    for (int i = 0; i < 16; i++) begin
      logic [3:0] q;
      q = i[0] ? AGU : ALU;
      acc(q, 4'(i), q, 2'b00);
    end
    stall(ALU, 4'd0, 0, 0, 0);
    stall(ALU, 4'd0, 1, 0, 0);
    acc(ALU, 4'd0, 4'd0, 2'b00);
    stall(AGU, 4'd0, 0, 0, 0);

    // 4: JALR holds dispatch until br_resolved; br_resolved in RUN ignored
    rst_v();
    idle(4'd0, 0, 1);
    acc(ALU, 4'd0, 4'd0, 2'b10);
    stall(ALU, 4'd0, 0, 0, 0);
    stall(ALU, 4'd0, 0, 0, 0);
    stall(ALU, 4'd0, 0, 0, 0);
    stall(ALU, 4'd0, 0, 1, 0);
    acc(ALU, 4'd1, 4'd0, 2'b00);
    acc(MUL, 4'd2, 4'd0, 2'b01);
    stall(MUL, 4'd0, 0, 0, 0);

    // 5: flush with retire in WAIT_BR: tail = head = 1, credits refilled
    rst_v();
    for (int i = 0; i < 3; i++) acc(ALU, 4'(i), 4'd0, 2'b00);
    acc(ALU, 4'd3, 4'd0, 2'b01);
    stall(ALU, 4'd0, 1, 0, 1);
    for (int i = 0; i < 4; i++) acc(ALU, 4'(1 + i), 4'd0, 2'b00);
    stall(ALU, 4'd0, 0, 0, 0);

    // 6: dropped instructions, dispatch_err, flush in RUN
    rst_v();
    add(0, 1, 4'd0, 0, 0, 4'd0, 0, 0, 0, 1, 4'd0, 0, 4'd0, 0);
    acc(ALU, 4'd0, 4'd0, 2'b00);
    add(0, 1, ALU | AGU, 0, 0, 4'd0, 0, 0, 0, 1, 4'd0, 0, 4'd0, 1);
    add(0, 0, ALU | AGU, 0, 0, 4'd0, 0, 0, 0, 1, 4'd0, 0, 4'd0, 0);
    acc(ALU, 4'd1, 4'd0, 2'b00);
    stall(ALU, 4'd0, 0, 0, 1);
    acc(ALU, 4'd0, 4'd0, 2'b00);

    rst_n = 1'b0; inst_valid = 1'b0;
    {queue_agu_en, queue_div_en, queue_mul_en, queue_alu_en} = 4'd0;
    ctrl_branch = 1'b0; ctrl_jmp_reg = 1'b0;
    {agu_issue, div_issue, mul_issue, alu_issue} = 4'd0;
    rob_retire = 1'b0; br_resolved = 1'b0; flush = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      v = tbl[i];
      rst_n       = !v.rst;
      inst_valid  = v.valid;
      {queue_agu_en, queue_div_en, queue_mul_en, queue_alu_en} = v.en;
      ctrl_branch = v.br;
      ctrl_jmp_reg = v.jr;
      {agu_issue, div_issue, mul_issue, alu_issue} = v.iss;
      rob_retire  = v.ret;
      br_resolved = v.res;
      flush       = v.fl;
      exp_q.push_back(v);

      @(negedge clk);
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL vec%0d scoreboard empty", i);
      end else begin
        e = exp_q.pop_front();
        chk("inst_ready", i, {3'b0, inst_ready}, {3'b0, e.ready});
        chk("push", i, {agu_push, div_push, mul_push, alu_push}, e.push);
        chk("rob_alloc", i, {3'b0, rob_alloc}, {3'b0, e.alloc});
        chk("dispatch_err", i, {3'b0, dispatch_err}, {3'b0, e.err});
        if (e.alloc) chk("rob_tag", i, rob_tag, e.tag);
      end
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dispatch_sched.md
Name: dispatch_sched

Overview:
Dispatch-stage scheduler for the Tomasulo core. It sits between the instruction decoder and the four issue queues (ALU, MUL, DIV, AGU). Per dispatched instruction it:
- tracks free slots in each queue with credit counters,
- allocates a ROB tag from a circular pointer,
- back-pressures fetch when the target queue or the ROB is full,
- serialises control flow by holding dispatch after a branch/JALR until it resolves.

Parameters:
ALU_DEPTH, 4, ALU issue-queue entries
MUL_DEPTH, 4, MUL issue-queue entries
DIV_DEPTH, 2, DIV issue-queue entries
AGU_DEPTH, 4, AGU issue-queue entries
ROB_DEPTH, 16, ROB entries (power of 2)
TAG_W, 4, log2(ROB_DEPTH)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
inst_valid  in  1  decoded instruction present
queue_alu_en/queue_mul_en/queue_div_en/queue_agu_en  in  1 each  target queue from decoder
ctrl_branch  in  1  instruction is a conditional branch
ctrl_jmp_reg  in  1  instruction is JALR
inst_ready  out  1  instruction accepted this cycle
alu_push/mul_push/div_push/agu_push  out  1 each  write strobe to that issue queue
rob_alloc  out  1  ROB entry allocated this cycle
rob_tag  out  TAG_W  tag for the dispatched instruction (ROB tail)
alu_issue/mul_issue/div_issue/agu_issue  in  1 each  queue popped one entry (returns one credit)
rob_retire  in  1  ROB head retired
br_resolved  in  1  pending branch/JALR resolved, no mispredict
flush  in  1  mispredict squash
dispatch_err  out  1  pulse: more than one queue enable asserted

Behaviour:
- Reset (async, rst_n=0) values:
  - credit_alu/mul/div/agu = *_DEPTH
  - rob_cnt=0, head=0, tail=0, state=RUN
  - all combinational outputs forced 0 while rst_n=0
- Target:
  - Exactly one enable asserted: that queue is the target.
  - No enable (invalid opcode): instruction is a NOP-drop. inst_ready=1 in RUN; no push, no alloc.
  - More than one enable: same as the no-enable case, plus dispatch_err=1 that cycle.
- inst_ready (combinational) = rst_n & !flush & state==RUN & (no valid target | (credit_target>0 & rob_cnt<ROB_DEPTH)).
- fire = inst_valid & inst_ready & valid single target.
  - On fire: target push=1, rob_alloc=1, rob_tag=tail, all in the same cycle.
  - Push outputs are 0 whenever fire=0.
- Credit counter width: clog2(DEPTH+1).
  - next = credit − push + issue.
  - Push and issue in the same cycle: unchanged.
  - Issue while credit==DEPTH is ignored (saturate, no overflow).
  - push while credit==0 cannot occur (gated by inst_ready).
- ROB:
  - rob_cnt next = rob_cnt + alloc − retire.
  - tail increments mod ROB_DEPTH on alloc; head increments mod ROB_DEPTH on retire.
  - Retire with rob_cnt==0 is ignored.
  - Alloc and retire in the same cycle at rob_cnt==ROB_DEPTH: not possible, since inst_ready uses the current count. Alloc is stalled that cycle and accepted the next.
- FSM:
  - RUN: on fire with ctrl_branch|ctrl_jmp_reg → WAIT_BR. Otherwise stay in RUN. br_resolved in RUN is ignored.
  - WAIT_BR: inst_ready=0. br_resolved → RUN, and dispatch resumes the following cycle.
  - flush (either state) has priority over everything; it takes effect at the next edge:
    - state=RUN, all credits=DEPTH
    - head advances by rob_retire first; then tail=head and rob_cnt=0
  - During the flush cycle: inst_ready=0, no push, no alloc.
- Latency: dispatch decision is 0 cycles (combinational on registered state). Credit, ROB and state updates are visible 1 cycle after the event.
- Wrap-around: tail 15→0 with rob_tag continuing 14, 15, 0, 1.

Test Plan:
1. Reset, 5 back-to-back ALU instrs, no alu_issue → alu_push on the first 4, rob_tag 0,1,2,3; 5th sees inst_ready=0. Pulse alu_issue → 5th accepted next cycle with tag 4.
2. DIV credit=1; same cycle div push + div_issue → credit stays 1. Then alu_issue with credit_alu=4 → stays 4, no overflow.
3. Alloc 16 mixed ALU/AGU with issues returning credits, no retire → 17th stalls (rob_cnt=16). rob_retire once → next cycle accepted with tag 0 (wrap).
4. Dispatch JALR (queue_alu_en, ctrl_jmp_reg) → WAIT_BR; inst_ready=0 for 3 cycles. br_resolved → next ALU instr accepted one cycle later with tag+1.
5. Three ALU pushes, branch dispatched (tags 0–3), then flush with rob_retire=1 in WAIT_BR → next cycle state RUN, credit_alu=4, head=1, tail=1, rob_cnt=0. Next dispatch gets tag 1.
6. inst_valid with no enable → inst_ready=1, no push, tail unchanged. ALU+AGU enables together → dispatch_err=1, no push, no alloc.
